div16_seq: RTL
==============

// Module: div16_seq
// PURPOSE
//  Iterative IEEE 754 half-precision divider: result = a / b. It is the inverse
//  operation to the FP16 multiplier and sits next to the FP16 adder/multiplier
//  in the neuron datapath, e.g. for normalisation and averaging.
//  Sequential radix-2 restoring divider with a start/done handshake and a fixed
//  latency of 14 cycles.
// PARAMETERS
//  tam     16   word width; the layout is fixed to 1 sign, 5 exponent, 10 mantissa bits
//  ITER    12   quotient bits produced: 1 integer bit + 11 fraction bits
// PORTS
//  clk          in   1    clock; all logic on the rising edge
//  rst          in   1    reset, synchronous, active-high
//  start        in   1    sampled only in IDLE; captures a and b
//  a            in   16   dividend, FP16
//  b            in   16   divisor, FP16
//  busy         out  1    high from the cycle after start is accepted until done
//  done         out  1    one-cycle pulse; result is valid from this cycle on
//  result       out  16   quotient, FP16; held until the next done
//  div_by_zero  out  1    updated with done; 1 when b was zero
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=16'h0000, div_by_zero=0.
//   Reset mid-operation aborts the operation and no done is produced.
//  FSM states and latency (start sampled high on edge T):
//   IDLE --start--> DIV (edges T+1..T+12) -> NORM (T+13) -> DONE (done=1, busy=0
//   after edge T+14) -> IDLE. Done is high for exactly one cycle.
//  start in any state other than IDLE is ignored. No queuing.
//  Capture at T: sign = a[15]^b[15]; ma = {1,a[9:0]}; mb = {1,b[9:0]};
//   e = a[14:10] - b[14:10] + 15, held as 7-bit signed.
//   Exponent 0 and exponent 31 inputs get no special treatment.
//   They are handled as normal numbers with an implied leading 1.
//  DIV: 12-bit remainder r is initialised to ma. Each cycle:
//   if r >= mb, then qbit=1 and r = r - mb; otherwise qbit=0.
//   Then r = r << 1 and q = {q[10:0], qbit}. The result is q = floor(ma*2^11/mb).
//  NORM: if q[11]=1, mant = q[10:1] and the exponent stays e.
//   Otherwise mant = q[9:0] and the exponent is e-1.
//   Rounding is by truncation only.
//  Result priority, evaluated in NORM:
//   1. a[14:0]==0 and b[14:0]==0 -> 16'h7E00 (NaN), div_by_zero=1
//   2. b[14:0]==0 -> {sign,5'h1F,10'h0}, div_by_zero=1
//   3. a[14:0]==0 -> 16'h0000
//   4. exponent >= 31 -> {sign,5'h1F,10'h0} (overflow to infinity)
//   5. exponent <= 0 -> 16'h0000 (underflow flushes to zero)
//   6. otherwise -> {sign, exponent[4:0], mant}
//  Special cases still run the full 14-cycle path, so latency is constant.
//  a and b may change after capture without affecting the operation in flight.
//  div_by_zero is 0 for every non-zero divisor.
// TESTING
//  3C00/3C00 -> result=3C00, div_by_zero=0; done exactly 14 cycles after start.
//  3C00/4200 (1/3) -> 3555; 4600/4000 (6/2) -> 4200; BE00/3800 (-1.5/0.5) -> C200.
//  3C00/0000 -> 7C00, div_by_zero=1; 0000/0000 -> 7E00, div_by_zero=1;
//   0000/4000 -> 0000, div_by_zero=0.
//  7BFF/1400 -> 7C00 (overflow); 0400/7800 -> 0000 (underflow).
//  start pulsed again at T+5 with other operands -> ignored; the first result
//   is delivered at T+14 and exactly one done pulse occurs.
//  rst asserted at T+6 -> busy=0, result=0000, no done; a fresh start completes
//   normally.

Source files
------------

// File: rtl/div16_seq.sv
// Iterative FP16 divider: result = a / b using a radix-2 restoring mantissa
// divider, with a start/done handshake and a constant 14-cycle latency.
module div16_seq #(
  parameter int unsigned tam  = 16,
  parameter int unsigned ITER = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [tam-1:0] a,
  input  logic [tam-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [tam-1:0] result,
  output logic           div_by_zero
);

  localparam int unsigned MW    = 11;        // mantissa with implied leading one
  localparam int unsigned RW    = ITER;      // remainder / quotient width
  localparam int unsigned EW    = 7;         // signed working exponent
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t state, state_nxt;

  logic                 sign;
  logic                 a_zero, b_zero;
  logic [MW-1:0]        mb;
  logic [RW-1:0]        r, r_nxt;
  logic [RW-1:0]        q;
  logic                 qbit;
  logic signed [EW-1:0] e, exp_n;
  logic [9:0]           mant_n;
  logic [CNT_W-1:0]     cnt;
  logic [tam-1:0]       res_hold, res_n;
  logic                 dz_hold, dz_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = DIV;
      DIV:  if (cnt == CNT_W'(ITER - 1)) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step and the normalise/special-case result selection
  always_comb begin
    qbit   = (r >= RW'(mb));
    r_nxt  = qbit ? (r - RW'(mb)) : r;
    exp_n  = q[RW-1] ? e : (e - EW'(1));
    mant_n = q[RW-1] ? q[10:1] : q[9:0];
    res_n  = {sign, exp_n[4:0], mant_n};
    dz_n   = 1'b0;
    if (a_zero && b_zero) begin
      res_n = 16'h7E00;
      dz_n  = 1'b1;
    end else if (b_zero) begin
      res_n = {sign, 5'h1F, 10'h000};
      dz_n  = 1'b1;
    end else if (a_zero) begin
      res_n = 16'h0000;
    end else if (exp_n >= EW'(31)) begin
      res_n = {sign, 5'h1F, 10'h000};
    end else if (exp_n <= EW'(0)) begin
      res_n = 16'h0000;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      sign        <= 1'b0;
      a_zero      <= 1'b0;
      b_zero      <= 1'b0;
      mb          <= '0;
      r           <= '0;
      q           <= '0;
      e           <= '0;
      cnt         <= '0;
      res_hold    <= '0;
      dz_hold     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy   <= 1'b1;
          sign   <= a[15] ^ b[15];
          a_zero <= (a[14:0] == 15'h0000);
          b_zero <= (b[14:0] == 15'h0000);
          r      <= RW'({1'b1, a[9:0]});
          mb     <= {1'b1, b[9:0]};
          e      <= EW'({2'b00, a[14:10]}) - EW'({2'b00, b[14:10]}) + EW'(15);
          q      <= '0;
          cnt    <= '0;
        end
        DIV: begin
          r   <= r_nxt << 1;
          q   <= {q[RW-2:0], qbit};
          cnt <= cnt + CNT_W'(1);
        end
        NORM: begin
          res_hold <= res_n;
          dz_hold  <= dz_n;
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          result      <= res_hold;
          div_by_zero <= dz_hold;
        end
        default: ;
      endcase
    end
  end

endmodule
